// File: rtl/fpu_issue_ctrl_if.sv
// fpu_issue_ctrl_if: PE-side instruction, load, FPU and result signals of the FPU issue stage.
interface fpu_issue_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 6
);
    logic                  Exec_En_Global;
    logic                  Instr_Valid_i;
    logic                  Instr_Ready_o;
    logic [OP_WIDTH-1:0]   Op_i;
    logic [1:0]            Src_Sel_A_i;
    logic [1:0]            Src_Sel_B_i;
    logic [DATA_WIDTH-1:0] Reg_A_i;
    logic [DATA_WIDTH-1:0] Reg_B_i;
    logic [DATA_WIDTH-1:0] load_data_i;
    logic                  data_req_valid_i;
    logic                  Enable_SI;
    logic [DATA_WIDTH-1:0] Operand_a_DI;
    logic [DATA_WIDTH-1:0] Operand_b_DI;
    logic [OP_WIDTH-1:0]   OP_SI;
    logic [DATA_WIDTH-1:0] Fpu_Result_i;
    logic                  Fpu_Valid_i;
    logic [DATA_WIDTH-1:0] Result_o;
    logic                  Result_Valid_o;
    logic                  Busy_o;
    logic                  Err_o;

    modport master (
        output Exec_En_Global, Instr_Valid_i, Op_i, Src_Sel_A_i, Src_Sel_B_i, Reg_A_i, Reg_B_i,
               load_data_i, data_req_valid_i, Fpu_Result_i, Fpu_Valid_i,
        input  Instr_Ready_o, Enable_SI, Operand_a_DI, Operand_b_DI, OP_SI, Result_o,
               Result_Valid_o, Busy_o, Err_o
    );

    modport slave (
        input  Exec_En_Global, Instr_Valid_i, Op_i, Src_Sel_A_i, Src_Sel_B_i, Reg_A_i, Reg_B_i,
               load_data_i, data_req_valid_i, Fpu_Result_i, Fpu_Valid_i,
        output Instr_Ready_o, Enable_SI, Operand_a_DI, Operand_b_DI, OP_SI, Result_o,
               Result_Valid_o, Busy_o, Err_o
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: serialising issue/operand-collect stage in front of the PE FPU, with result hold and watchdog.
module fpu_issue_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 6,
    parameter int LATENCY    = 2
) (
    input logic            Clk,
    input logic            Reset,
    fpu_issue_ctrl_if.slave bus
);
    localparam int WD = 4 * LATENCY;
    localparam int CW = $clog2(WD + 1);

    typedef enum logic [1:0] {IDLE, WAIT_LD, ISSUE, EXEC} state_t;

    state_t                r_state, w_next;
    logic [OP_WIDTH-1:0]   r_op, r_ops;
    logic [1:0]            r_sel_a, r_sel_b;
    logic [DATA_WIDTH-1:0] r_reg_a, r_reg_b, r_opa, r_opb, r_res;
    logic [CW-1:0]         r_cnt;
    logic                  r_en, r_res_v, r_err;
    logic                  w_accept, w_done, w_tmo, w_need_ld;
    logic [1:0]            w_sel_a, w_sel_b;
    logic [DATA_WIDTH-1:0] w_reg_a, w_reg_b;
    logic [OP_WIDTH-1:0]   w_op;

    function automatic logic [DATA_WIDTH-1:0] pick(input logic [1:0] s, input logic [DATA_WIDTH-1:0] r,
                                                   input logic [DATA_WIDTH-1:0] ld, input logic [DATA_WIDTH-1:0] pv);
        return s == 2'b00 ? r : s == 2'b01 ? ld : s == 2'b10 ? pv : '0;
    endfunction

    assign bus.Instr_Ready_o  = (r_state == IDLE) & bus.Exec_En_Global & Reset;
    assign bus.Enable_SI      = r_en;
    assign bus.Operand_a_DI   = r_opa;
    assign bus.Operand_b_DI   = r_opb;
    assign bus.OP_SI          = r_ops;
    assign bus.Result_o       = r_res;
    assign bus.Result_Valid_o = r_res_v;
    assign bus.Busy_o         = r_state != IDLE;
    assign bus.Err_o          = r_err;

    // Operands can be issued straight from the accept cycle, so sources bypass the latches in IDLE.
    assign w_accept  = bus.Instr_Valid_i & bus.Instr_Ready_o;
    assign w_sel_a   = r_state == IDLE ? bus.Src_Sel_A_i : r_sel_a;
    assign w_sel_b   = r_state == IDLE ? bus.Src_Sel_B_i : r_sel_b;
    assign w_reg_a   = r_state == IDLE ? bus.Reg_A_i : r_reg_a;
    assign w_reg_b   = r_state == IDLE ? bus.Reg_B_i : r_reg_b;
    assign w_op      = r_state == IDLE ? bus.Op_i : r_op;
    assign w_need_ld = (w_sel_a == 2'b01) | (w_sel_b == 2'b01);
    assign w_done    = (r_state == EXEC) & bus.Fpu_Valid_i;
    assign w_tmo     = (r_state == EXEC) & ~bus.Fpu_Valid_i & (r_cnt == CW'(WD - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? ((w_need_ld & ~bus.data_req_valid_i) ? WAIT_LD : ISSUE) : IDLE;
            WAIT_LD: w_next = bus.data_req_valid_i ? ISSUE : WAIT_LD;
            ISSUE:   w_next = EXEC;
            EXEC:    w_next = (w_done | w_tmo) ? IDLE : EXEC;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_sel_a <= '0;
            r_sel_b <= '0;
            r_reg_a <= '0;
            r_reg_b <= '0;
            r_en    <= 1'b0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_ops   <= '0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_res_v <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op    <= bus.Op_i;
                r_sel_a <= bus.Src_Sel_A_i;
                r_sel_b <= bus.Src_Sel_B_i;
                r_reg_a <= bus.Reg_A_i;
                r_reg_b <= bus.Reg_B_i;
            end
            r_en <= w_next == ISSUE;
            if (w_next == ISSUE) begin
                r_opa <= pick(w_sel_a, w_reg_a, bus.load_data_i, r_res);
                r_opb <= pick(w_sel_b, w_reg_b, bus.load_data_i, r_res);
                r_ops <= w_op;
            end
            r_cnt   <= r_state == EXEC ? r_cnt + CW'(1) : '0;
            r_res_v <= w_done;
            // Result_o doubles as the previous-result operand source.
            if (w_done) r_res <= bus.Fpu_Result_i;
            if (w_tmo) r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: randomized transaction-level check of fpu_issue_ctrl against a cycle-budget reference model.
module tb_fpu_issue_ctrl;
    logic Clk = 1'b0;
    logic Reset = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [31:0] m_res = '0;
    logic        m_err = 1'b0;

    fpu_issue_ctrl_if #(.DATA_WIDTH(32), .OP_WIDTH(6)) bus ();

    fpu_issue_ctrl #(.DATA_WIDTH(32), .OP_WIDTH(6), .LATENCY(2)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] src(input logic [1:0] s, input logic [31:0] r, input logic [31:0] ld);
        case (s)
            2'd0:    return r;
            2'd1:    return ld;
            2'd2:    return m_res;
            default: return 32'd0;
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the completion cycle.
    // ldly: cycle after accept in which load data arrives (0 = same cycle); lat: EXEC cycle of Fpu_Valid_i (>8 = never).
    task automatic run_op(input logic [5:0] op, input logic [1:0] sa, input logic [1:0] sb,
                          input logic [31:0] ra, input logic [31:0] rb, input logic [31:0] ldd,
                          input int ldly, input int lat, input logic [31:0] res, input bit drop_en);
        bit          uses_ld = (sa == 2'd1) || (sb == 2'd1);
        int          e = (uses_ld ? ldly : 0) + 1;
        bit          ok = lat <= 8;
        int          done = ok ? e + lat + 1 : e + 9;
        logic [31:0] exp_a = src(sa, ra, ldd);
        logic [31:0] exp_b = src(sb, rb, ldd);
        logic [31:0] new_res = ok ? res : m_res;
        bit          new_err = m_err | !ok;
        bus.Exec_En_Global = 1'b1;
        #1;
        chk("ready_accept", bus.Instr_Ready_o, 1);
        bus.Instr_Valid_i    = 1'b1;
        bus.Op_i             = op;
        bus.Src_Sel_A_i      = sa;
        bus.Src_Sel_B_i      = sb;
        bus.Reg_A_i          = ra;
        bus.Reg_B_i          = rb;
        bus.data_req_valid_i = uses_ld ? (ldly == 0) : 1'($urandom);
        bus.load_data_i      = (uses_ld && ldly == 0) ? ldd : $urandom;
        bus.Fpu_Valid_i      = 1'($urandom);
        bus.Fpu_Result_i     = $urandom;
        for (int c = 1; c <= done; c++) begin
            @(negedge Clk);
            chk("enable", bus.Enable_SI, c == e);
            if (c == e) begin
                chk("opa", bus.Operand_a_DI, exp_a);
                chk("opb", bus.Operand_b_DI, exp_b);
                chk("op", bus.OP_SI, op);
            end
            chk("busy", bus.Busy_o, c < done);
            chk("res_valid", bus.Result_Valid_o, c == done && ok);
            chk("result", bus.Result_o, c == done ? new_res : m_res);
            chk("err", bus.Err_o, c == done ? new_err : m_err);
            if (c < done) chk("ready_busy", bus.Instr_Ready_o, 0);
            bus.Instr_Valid_i    = 1'b0;
            bus.data_req_valid_i = uses_ld && ldly > 0 && c == ldly;
            bus.load_data_i      = (uses_ld && c == ldly) ? ldd : $urandom;
            bus.Fpu_Valid_i      = (ok && c == e + lat) ? 1'b1 : (c <= e ? 1'($urandom) : 1'b0);
            bus.Fpu_Result_i     = (ok && c == e + lat) ? res : $urandom;
            bus.Exec_En_Global   = !(drop_en && c > e && c < done);
        end
        m_res = new_res;
        m_err = new_err;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"}, bus.Enable_SI, 0);
        chk({tag, "_opa"}, bus.Operand_a_DI, 0);
        chk({tag, "_opb"}, bus.Operand_b_DI, 0);
        chk({tag, "_op"}, bus.OP_SI, 0);
        chk({tag, "_res"}, bus.Result_o, 0);
        chk({tag, "_rv"}, bus.Result_Valid_o, 0);
        chk({tag, "_err"}, bus.Err_o, 0);
        chk({tag, "_busy"}, bus.Busy_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.Exec_En_Global   = 1'b1;
        bus.Instr_Valid_i    = 1'b0;
        bus.Op_i             = '0;
        bus.Src_Sel_A_i      = '0;
        bus.Src_Sel_B_i      = '0;
        bus.Reg_A_i          = '0;
        bus.Reg_B_i          = '0;
        bus.load_data_i      = '0;
        bus.data_req_valid_i = 1'b0;
        bus.Fpu_Result_i     = '0;
        bus.Fpu_Valid_i      = 1'b0;
        repeat (3) @(negedge Clk);
        chk_all_zero("reset");
        chk("reset_ready", bus.Instr_Ready_o, 0);
        Reset = 1'b1;
        @(negedge Clk);
        run_op(6'b011010, 2'd0, 2'd3, 32'h3F80_0000, 32'h1111_1111, 32'h0, 0, 2, 32'h3F80_0000, 0);
        run_op(6'h05, 2'd1, 2'd0, 32'hDEAD_BEEF, 32'h0000_0001, 32'h4000_0000, 3, 2, 32'h4040_0000, 0);
        run_op(6'h07, 2'd0, 2'd0, 32'h1, 32'h2, 32'h0, 0, 2, 32'h1234_5678, 0);
        run_op(6'h08, 2'd0, 2'd2, 32'h3, 32'h4, 32'h0, 0, 2, 32'h0BAD_F00D, 1);
        run_op(6'h09, 2'd1, 2'd1, 32'h5, 32'h6, 32'hCAFE_0001, 0, 8, 32'h7777_0000, 0);
        // Instruction held off while global execute permission is low.
        bus.Exec_En_Global = 1'b0;
        bus.Instr_Valid_i  = 1'b1;
        #1;
        chk("noen_ready", bus.Instr_Ready_o, 0);
        repeat (3) begin
            @(negedge Clk);
            chk("noen_enable", bus.Enable_SI, 0);
            chk("noen_busy", bus.Busy_o, 0);
        end
        bus.Instr_Valid_i = 1'b0;
        for (int k = 0; k < 40; k++)
            run_op(6'($urandom), 2'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(1, 8),
                   $urandom, 1'($urandom));
        run_op(6'h11, 2'd2, 2'd0, 32'h0, 32'h9, 32'h0, 0, 20, 32'hFFFF_FFFF, 0);
        // Asynchronous reset in the middle of EXEC, then a stray FPU valid.
        run_op(6'h12, 2'd0, 2'd0, 32'hA, 32'hB, 32'h0, 0, 1, 32'h5555_AAAA, 0);
        bus.Instr_Valid_i = 1'b1;
        bus.Fpu_Valid_i   = 1'b0;
        repeat (4) begin
            @(negedge Clk);
            bus.Instr_Valid_i = 1'b0;
        end
        chk("mid_busy", bus.Busy_o, 1);
        Reset = 1'b0;
        #1;
        chk_all_zero("midrst");
        chk("midrst_ready", bus.Instr_Ready_o, 0);
        m_res = '0;
        m_err = 1'b0;
        @(negedge Clk);
        Reset             = 1'b1;
        bus.Fpu_Valid_i   = 1'b1;
        bus.Fpu_Result_i  = 32'hFACE_FACE;
        @(negedge Clk);
        bus.Fpu_Valid_i = 1'b0;
        chk_all_zero("spurious");
        run_op(6'h13, 2'd2, 2'd2, 32'h1, 32'h2, 32'h0, 0, 2, 32'h0101_0101, 0);
        run_op(6'h14, 2'd2, 2'd1, 32'h1, 32'h2, 32'h8888_0000, 2, 3, 32'h0202_0202, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Issue and operand-collect stage directly upstream of the processing element's FPU. It accepts one FPU instruction at a time and selects each operand from a register value, returning load data, the previous FPU result or zero. It then pulses the FPU enable with registered operands and captures the FPU result into a held output. It serialises instructions, and its busy output stalls the PE controller while an operation is in flight.

## Interface
- DATA_WIDTH, 32: operand and result width
- OP_WIDTH, 6: FPU opcode width
- LATENCY, 2: nominal cycles from Enable_SI pulse to Fpu_Valid_i
- Clk  in  1  clock, all logic on rising edge
- Reset  in  1  asynchronous, active-low reset
- Exec_En_Global  in  1  global execute permission; gates acceptance only
- Instr_Valid_i  in  1  FPU instruction presented
- Instr_Ready_o  out  1  instruction accepted when high with Instr_Valid_i
- Op_i  in  OP_WIDTH  opcode
- Src_Sel_A_i, Src_Sel_B_i  in  2 each  operand source: 00 register, 01 load data, 10 previous result, 11 zero
- Reg_A_i, Reg_B_i  in  DATA_WIDTH  register operands
- load_data_i  in  DATA_WIDTH  memory load data
- data_req_valid_i  in  1  load_data_i valid this cycle
- Enable_SI  out  1  one-cycle FPU start pulse
- Operand_a_DI, Operand_b_DI  out  DATA_WIDTH  registered FPU operands
- OP_SI  out  OP_WIDTH  registered FPU opcode
- Fpu_Result_i  in  DATA_WIDTH  FPU result
- Fpu_Valid_i  in  1  FPU result valid
- Result_o  out  DATA_WIDTH  last completed result (held)
- Result_Valid_o  out  1  one-cycle pulse, new Result_o
- Busy_o  out  1  high in any state other than IDLE
- Err_o  out  1  sticky watchdog timeout flag

## Operation
- FSM states are IDLE, WAIT_LD, ISSUE and EXEC. Reset sends the FSM to IDLE.
- Instr_Ready_o = (state==IDLE) & Exec_En_Global & Reset (combinational).
- IDLE: on accept, latch Op_i, both selects, Reg_A_i and Reg_B_i.
  - If a select is 01 and data_req_valid_i is high in the same cycle, capture load_data_i.
  - The next state is WAIT_LD if any select is 01 and no load data was captured; otherwise it is ISSUE.
- WAIT_LD: capture load_data_i on the first data_req_valid_i and go to ISSUE. The same load word feeds both operands if both selects are 01.
- ISSUE: Enable_SI=1 for exactly one cycle. Operand_a_DI, Operand_b_DI and OP_SI are set from the latched sources at the edge entering ISSUE. The watchdog counter is cleared and the FSM goes to EXEC.
- Previous-result register prev_q:
  - resets to 0;
  - is updated only on completion;
  - is the source for select 10.
- EXEC: the counter increments every cycle.
  - On Fpu_Valid_i: Result_o and prev_q take Fpu_Result_i, Result_Valid_o pulses in the following cycle, and the FSM goes to IDLE.
  - Watchdog: if counter reaches 4*LATENCY without Fpu_Valid_i, set Err_o, go to IDLE, leave Result_o and prev_q unchanged, and give no Result_Valid_o.
- Fpu_Valid_i outside EXEC is ignored.
- Deasserting Exec_En_Global mid-operation does not abort it; the in-flight op completes.
- Err_o clears only on reset.
- Operand_a_DI, Operand_b_DI and OP_SI hold their last values outside ISSUE.

## Timing
- All registered outputs reset to 0 (Enable_SI, operands, OP_SI, Result_o, Result_Valid_o, Err_o); Busy_o=0.
- No load wait: accept edge T, Enable_SI high in cycle T+1, Fpu_Valid_i expected in cycle T+1+LATENCY, Result_Valid_o in cycle T+2+LATENCY.
- Each WAIT_LD cycle adds one cycle of latency.
- Earliest next accept is the cycle where Result_Valid_o is high (IDLE). An instruction accepted there with select 10 sees the new prev_q.
- Reset asserted mid-operation: immediate return to IDLE, outputs to reset values, latched instruction discarded.
- Counter width must hold 4*LATENCY without wrap.

## Test plan
- Reset then single op: A=reg 0x3F800000, B=zero, Op=6'b011010, FPU model returns 0x3F800000 after 2 cycles -> Enable_SI pulse 1 cycle after accept, Result_o=0x3F800000, Result_Valid_o 4 cycles after accept, Busy_o high in between.
- Load operand with delayed data: Src_Sel_A=01, data_req_valid_i high 3 cycles after accept with 0x40000000 -> Operand_a_DI=0x40000000, Enable_SI 1 cycle after data, total latency +3.
- Chaining: the first op returns 0x12345678; a second op with Src_Sel_B=10 is accepted in the Result_Valid_o cycle -> Operand_b_DI=0x12345678.
- Exec_En_Global=0 with Instr_Valid_i=1 -> Instr_Ready_o=0, no Enable_SI. Dropping Exec_En_Global during EXEC -> op still completes.
- Watchdog: FPU never returns valid -> after 8 EXEC cycles Err_o=1, Busy_o=0, Result_o unchanged, no Result_Valid_o.
- Reset pulse during EXEC -> all outputs 0 and state IDLE at once; a spurious Fpu_Valid_i afterwards is ignored.
